// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data scratchpad between the load queue and the store buffer.
// Define DMEM_ARB_RR_EN to select round-robin arbitration instead of LQ priority with starvation.
module dmem_port_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lq_req_valid,
  output logic            lq_req_ready,
  input  logic [XLEN-1:0] lq_addr,
  input  logic [1:0]      lq_size,
  output logic            lq_resp_valid,
  output logic [XLEN-1:0] lq_resp_data,
  output logic            lq_resp_error,
  input  logic            sb_req_valid,
  output logic            sb_req_ready,
  input  logic [XLEN-1:0] sb_addr,
  input  logic [XLEN-1:0] sb_wdata,
  input  logic [1:0]      sb_size,
  input  logic            sb_atomic,
  input  logic [XLEN-1:0] sb_cmp_val,
  output logic            sb_resp_valid,
  output logic [XLEN-1:0] sb_resp_data,
  output logic            sb_resp_error,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_atomic,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_cmp_val,
  output logic [1:0]      mem_size,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_error
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic            owner_sb_q;
  logic            we_q;
  logic            atomic_q;
  logic            mem_req_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] cmp_q;
  logic [1:0]      size_q;
  logic [TW-1:0]   tmo_q;

  logic            lq_resp_valid_q;
  logic            lq_resp_error_q;
  logic [XLEN-1:0] lq_resp_data_q;
  logic            sb_resp_valid_q;
  logic            sb_resp_error_q;
  logic [XLEN-1:0] sb_resp_data_q;

  logic            sb_win;
  logic            idle;
  logic            resp_set;
  logic            resp_err;
  logic [XLEN-1:0] resp_dat;

`ifdef DMEM_ARB_RR_EN
  logic last_sb_q;

  // The port granted last time yields whenever the other one is waiting.
  assign sb_win = sb_req_valid && (!lq_req_valid || !last_sb_q);
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;

  assign sb_win = sb_req_valid && (!lq_req_valid || (starve_q == StarveMax));
`endif

  assign idle         = (state_q == StIdle) && !reset;
  assign lq_req_ready = idle && lq_req_valid && !sb_win;
  assign sb_req_ready = idle && sb_win;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_req_q && we_q;
  assign mem_atomic  = mem_req_q && atomic_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_cmp_val = cmp_q;
  assign mem_size    = size_q;

  assign lq_resp_valid = lq_resp_valid_q;
  assign lq_resp_data  = lq_resp_data_q;
  assign lq_resp_error = lq_resp_error_q;
  assign sb_resp_valid = sb_resp_valid_q;
  assign sb_resp_data  = sb_resp_data_q;
  assign sb_resp_error = sb_resp_error_q;

  // Response to be registered on the transition into StResp.
  always_comb begin
    resp_set = 1'b0;
    resp_err = 1'b0;
    resp_dat = '0;
    if (state_q == StIssue && mem_error) begin
      resp_set = 1'b1;
      resp_err = 1'b1;
    end else if (state_q == StWait) begin
      if (mem_ready) begin
        resp_set = 1'b1;
        // Plain stores return zero; loads and CAS return the old memory word.
        resp_dat = (owner_sb_q && !atomic_q) ? '0 : mem_rdata;
      end else if (tmo_q == TmoLast) begin
        resp_set = 1'b1;
        resp_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      owner_sb_q      <= 1'b0;
      we_q            <= 1'b0;
      atomic_q        <= 1'b0;
      mem_req_q       <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      cmp_q           <= '0;
      size_q          <= '0;
      tmo_q           <= '0;
      lq_resp_valid_q <= 1'b0;
      lq_resp_error_q <= 1'b0;
      lq_resp_data_q  <= '0;
      sb_resp_valid_q <= 1'b0;
      sb_resp_error_q <= 1'b0;
      sb_resp_data_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_sb_q       <= 1'b1;
`else
      starve_q        <= '0;
`endif
    end else begin
      mem_req_q       <= 1'b0;
      lq_resp_valid_q <= resp_set && !owner_sb_q;
      lq_resp_error_q <= resp_set && !owner_sb_q && resp_err;
      lq_resp_data_q  <= (resp_set && !owner_sb_q) ? resp_dat : '0;
      sb_resp_valid_q <= resp_set && owner_sb_q;
      sb_resp_error_q <= resp_set && owner_sb_q && resp_err;
      sb_resp_data_q  <= (resp_set && owner_sb_q) ? resp_dat : '0;

      case (state_q)
        StIdle: begin
          if (lq_req_ready || sb_req_ready) begin
            owner_sb_q <= sb_req_ready;
            addr_q     <= sb_req_ready ? sb_addr : lq_addr;
            size_q     <= sb_req_ready ? sb_size : lq_size;
            wdata_q    <= sb_req_ready ? sb_wdata : '0;
            cmp_q      <= sb_req_ready ? sb_cmp_val : '0;
            we_q       <= sb_req_ready && !sb_atomic;
            atomic_q   <= sb_req_ready && sb_atomic;
            mem_req_q  <= 1'b1;
            tmo_q      <= '0;
            state_q    <= StIssue;
`ifdef DMEM_ARB_RR_EN
            last_sb_q  <= sb_req_ready;
`else
            if (sb_req_ready) begin
              starve_q <= '0;
            end else if (sb_req_valid) begin
              starve_q <= starve_q + 1'b1;
            end
`endif
          end
        end
        StIssue: state_q <= mem_error ? StResp : StWait;
        StWait: begin
          if (resp_set) begin
            state_q <= StResp;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: word-granular scratchpad stub plus a transaction-level reference
// model; honours DMEM_ARB_RR_EN for the expected grant order.
module tb_dmem_port_arbiter;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned STARVE_LIMIT   = 4;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            lq_req_valid = 1'b0;
  logic            lq_req_ready;
  logic [XLEN-1:0] lq_addr = '0;
  logic [1:0]      lq_size = '0;
  logic            lq_resp_valid;
  logic [XLEN-1:0] lq_resp_data;
  logic            lq_resp_error;
  logic            sb_req_valid = 1'b0;
  logic            sb_req_ready;
  logic [XLEN-1:0] sb_addr = '0;
  logic [XLEN-1:0] sb_wdata = '0;
  logic [1:0]      sb_size = '0;
  logic            sb_atomic = 1'b0;
  logic [XLEN-1:0] sb_cmp_val = '0;
  logic            sb_resp_valid;
  logic [XLEN-1:0] sb_resp_data;
  logic            sb_resp_error;
  logic            mem_req;
  logic            mem_we;
  logic            mem_atomic;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_cmp_val;
  logic [1:0]      mem_size;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_error;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int mem_req_cnt = 0;
  bit hang = 1'b0;
  bit init_done = 1'b0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  dmem_port_arbiter #(
    .XLEN          (XLEN),
    .STARVE_LIMIT  (STARVE_LIMIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lq_req_valid (lq_req_valid),
    .lq_req_ready (lq_req_ready),
    .lq_addr      (lq_addr),
    .lq_size      (lq_size),
    .lq_resp_valid(lq_resp_valid),
    .lq_resp_data (lq_resp_data),
    .lq_resp_error(lq_resp_error),
    .sb_req_valid (sb_req_valid),
    .sb_req_ready (sb_req_ready),
    .sb_addr      (sb_addr),
    .sb_wdata     (sb_wdata),
    .sb_size      (sb_size),
    .sb_atomic    (sb_atomic),
    .sb_cmp_val   (sb_cmp_val),
    .sb_resp_valid(sb_resp_valid),
    .sb_resp_data (sb_resp_data),
    .sb_resp_error(sb_resp_error),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_atomic   (mem_atomic),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_cmp_val  (mem_cmp_val),
    .mem_size     (mem_size),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req) mem_req_cnt <= mem_req_cnt + 1;
  end

  function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || (s == 2'b11);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h9E37_79B9 * (i + 1);
  endfunction

  // Scratchpad stub: whole-word storage, rejects misaligned requests combinationally.
  assign mem_error = mem_req && misal(mem_addr, mem_size);

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else if (reset) begin
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= $urandom;
      if (mem_req && !mem_error && !hang) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[7:2]];
        if (mem_we || (mem_atomic && mem[mem_addr[7:2]] == mem_cmp_val))
          mem[mem_addr[7:2]] <= mem_wdata;
      end
    end
  end

  // Transaction-level expectation; updates the reference memory in grant order.
  function automatic void model(input bit is_sb, input bit at, input logic [31:0] a,
                                input logic [1:0] s, input logic [31:0] wd,
                                input logic [31:0] cv, output logic [31:0] d, output bit e);
    logic [31:0] old;
    old = ref_mem[a[7:2]];
    e = misal(a, s);
    d = '0;
    if (!e) begin
      if (!is_sb || at) d = old;
      if (is_sb && (!at || old == cv)) ref_mem[a[7:2]] = wd;
    end
  endfunction

  // Drives one request on one port and reports what came back. Starts and ends just after a
  // rising edge.
  task automatic txn(input bit is_sb, input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] wd, input logic [31:0] cv, input bit at,
                     output int lat, output logic [31:0] rd, output bit re, output bit stray,
                     output int nreq);
    int acc;
    int n0;
    bit got;
    lat = -1; rd = '0; re = 1'b0; stray = 1'b0; acc = -1; got = 1'b0;
    n0 = mem_req_cnt;
    if (is_sb) begin
      sb_req_valid = 1'b1; sb_addr = a; sb_size = s; sb_wdata = wd; sb_cmp_val = cv;
      sb_atomic = at;
    end else begin
      lq_req_valid = 1'b1; lq_addr = a; lq_size = s;
    end
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (is_sb ? sb_req_ready : lq_req_ready) acc = cyc;
      @(posedge clk); #1;
    end
    lq_req_valid = 1'b0; sb_req_valid = 1'b0; sb_atomic = 1'b0;
    if (acc >= 0) begin
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (is_sb ? lq_resp_valid : sb_resp_valid) stray = 1'b1;
        if (is_sb ? sb_resp_valid : lq_resp_valid) begin
          got = 1'b1;
          lat = cyc - acc;
          rd = is_sb ? sb_resp_data : lq_resp_data;
          re = is_sb ? sb_resp_error : lq_resp_error;
        end
        @(posedge clk); #1;
      end
    end
    nreq = mem_req_cnt - n0;
  endtask

  task automatic test_reset();
    lq_req_valid = 1'b1; sb_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({lq_req_ready, sb_req_ready, lq_resp_valid, lq_resp_data, lq_resp_error, sb_resp_valid,
         sb_resp_data, sb_resp_error, mem_req, mem_we, mem_atomic, mem_addr, mem_wdata,
         mem_cmp_val, mem_size} !== '0)
      begin errs++; $display("FAIL reset_outputs: some output nonzero during reset, required all 0"); end
    lq_req_valid = 1'b0; sb_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_then_load();
    int lat, nreq; logic [31:0] rd; bit re, st; logic [31:0] ed; bit ee;
    model(1'b1, 1'b0, 32'h10, 2'b10, 32'hDEAD_BEEF, '0, ed, ee);
    txn(1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (lat !== 3 || rd !== 32'h0 || re !== 1'b0 || st || nreq != 1) begin
      errs++;
      $display("FAIL sb_write: lat=%0d data=%h err=%b stray=%b nreq=%0d, required 3 0 0 0 1",
               lat, rd, re, st, nreq);
    end
    model(1'b0, 1'b0, 32'h10, 2'b10, '0, '0, ed, ee);
    txn(1'b0, 32'h10, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF || re !== 1'b0 || st || nreq != 1) begin
      errs++;
      $display("FAIL lq_load_back: lat=%0d data=%h err=%b stray=%b nreq=%0d, required 3 deadbeef 0 0 1",
               lat, rd, re, st, nreq);
    end
  endtask

  task automatic test_misaligned();
    int lat, nreq; logic [31:0] rd; bit re, st; logic [31:0] ed; bit ee;
    model(1'b0, 1'b0, 32'h2, 2'b10, '0, '0, ed, ee);
    txn(1'b0, 32'h2, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (lat !== 2 || rd !== 32'h0 || re !== 1'b1 || st || nreq != 1) begin
      errs++;
      $display("FAIL lq_misaligned: lat=%0d data=%h err=%b stray=%b nreq=%0d, required 2 0 1 0 1",
               lat, rd, re, st, nreq);
    end
    model(1'b1, 1'b0, 32'h11, 2'b01, 32'h1234_5678, '0, ed, ee);
    txn(1'b1, 32'h11, 2'b01, 32'h1234_5678, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (lat !== 2 || rd !== 32'h0 || re !== 1'b1 || st || nreq != 1) begin
      errs++;
      $display("FAIL sb_misaligned: lat=%0d data=%h err=%b stray=%b nreq=%0d, required 2 0 1 0 1",
               lat, rd, re, st, nreq);
    end
    // The rejected half-word store must not have touched the word at 0x10.
    model(1'b0, 1'b0, 32'h10, 2'b10, '0, '0, ed, ee);
    txn(1'b0, 32'h10, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (rd !== 32'hDEAD_BEEF || re !== 1'b0) begin
      errs++;
      $display("FAIL misaligned_no_write: data=%h err=%b, required deadbeef 0", rd, re);
    end
  endtask

  task automatic test_cas();
    int lat, nreq; logic [31:0] rd; bit re, st; logic [31:0] ed; bit ee;
    logic [31:0] exp_resp [0:3];
    exp_resp[0] = 32'd5; exp_resp[1] = 32'd9; exp_resp[2] = 32'd9; exp_resp[3] = 32'd9;
    model(1'b1, 1'b0, 32'h20, 2'b10, 32'd5, '0, ed, ee);
    txn(1'b1, 32'h20, 2'b10, 32'd5, '0, 1'b0, lat, rd, re, st, nreq);
    for (int k = 0; k < 4; k++) begin
      // Even steps: CAS cmp 5 / new 9; odd steps: load back.
      if (k % 2 == 0) begin
        model(1'b1, 1'b1, 32'h20, 2'b10, 32'd9, 32'd5, ed, ee);
        txn(1'b1, 32'h20, 2'b10, 32'd9, 32'd5, 1'b1, lat, rd, re, st, nreq);
      end else begin
        model(1'b0, 1'b0, 32'h20, 2'b10, '0, '0, ed, ee);
        txn(1'b0, 32'h20, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
      end
      checks++;
      if (lat !== 3 || rd !== exp_resp[k] || rd !== ed || re !== 1'b0 || st) begin
        errs++;
        $display("FAIL cas_step%0d: lat=%0d data=%h err=%b stray=%b, required 3 %h 0 0",
                 k, lat, rd, re, st, exp_resp[k]);
      end
    end
  endtask

  task automatic test_arbitration();
    int lat, nreq; logic [31:0] rd; bit re, st; logic [31:0] ed; bit ee;
    int grants, streak; bit pend, pend_sb, pend_err, exp_sb; logic [31:0] pend_data;
    // A lone SB grant clears the starvation count and leaves SB as last-granted.
    model(1'b1, 1'b0, 32'h40, 2'b10, 32'h1, '0, ed, ee);
    txn(1'b1, 32'h40, 2'b10, 32'h1, '0, 1'b0, lat, rd, re, st, nreq);
    grants = 0; streak = 0; pend = 1'b0; pend_sb = 1'b0; pend_err = 1'b0; pend_data = '0;
    lq_req_valid = 1'b1; lq_size = 2'b10; lq_addr = {24'h0, 2'b01, 4'($urandom), 2'b00};
    sb_req_valid = 1'b1; sb_size = 2'b10; sb_addr = {24'h0, 2'b01, 4'($urandom), 2'b00};
    sb_wdata = $urandom; sb_atomic = 1'b0;
    for (int c = 0; c < 200 && (grants < 10 || pend); c++) begin
      @(negedge clk);
      if (lq_resp_valid || sb_resp_valid) begin
        checks++;
        if (sb_resp_valid !== pend_sb || lq_resp_valid === sb_resp_valid || !pend ||
            (pend_sb ? sb_resp_data : lq_resp_data) !== pend_data ||
            (pend_sb ? sb_resp_error : lq_resp_error) !== pend_err) begin
          errs++;
          $display("FAIL arb_resp%0d: lq_v=%b sb_v=%b lq_d=%h sb_d=%h, required sb=%b data=%h",
                   grants, lq_resp_valid, sb_resp_valid, lq_resp_data, sb_resp_data, pend_sb,
                   pend_data);
        end
        pend = 1'b0;
      end
      if (lq_req_ready || sb_req_ready) begin
`ifdef DMEM_ARB_RR_EN
        exp_sb = (grants % 2 == 1);
`else
        exp_sb = (streak == STARVE_LIMIT);
`endif
        checks++;
        if (sb_req_ready !== exp_sb || (lq_req_ready && sb_req_ready)) begin
          errs++;
          $display("FAIL arb_grant%0d: lq_ready=%b sb_ready=%b, required sb grant=%b",
                   grants, lq_req_ready, sb_req_ready, exp_sb);
        end
        pend = 1'b1; pend_sb = sb_req_ready;
        if (sb_req_ready) model(1'b1, 1'b0, sb_addr, sb_size, sb_wdata, '0, pend_data, pend_err);
        else              model(1'b0, 1'b0, lq_addr, lq_size, '0, '0, pend_data, pend_err);
        streak = sb_req_ready ? 0 : streak + 1;
        grants++;
        @(posedge clk); #1;
        if (pend_sb) begin
          sb_addr = {24'h0, 2'b01, 4'($urandom), 2'b00}; sb_wdata = $urandom;
        end else begin
          lq_addr = {24'h0, 2'b01, 4'($urandom), 2'b00};
        end
        if (grants == 10) begin lq_req_valid = 1'b0; sb_req_valid = 1'b0; end
      end else begin
        @(posedge clk); #1;
      end
    end
    lq_req_valid = 1'b0; sb_req_valid = 1'b0;
    checks++;
    if (grants != 10 || pend) begin
      errs++;
      $display("FAIL arb_progress: grants=%0d pending=%b, required 10 grants all answered",
               grants, pend);
    end
  endtask

  task automatic test_timeout();
    int lat, nreq; logic [31:0] rd; bit re, st; logic [31:0] ed; bit ee;
    hang = 1'b1;
    txn(1'b0, 32'h30, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
    hang = 1'b0;
    checks++;
    if (lat !== 2 + TIMEOUT_CYCLES || rd !== 32'h0 || re !== 1'b1 || st || nreq != 1) begin
      errs++;
      $display("FAIL timeout: lat=%0d data=%h err=%b stray=%b nreq=%0d, required %0d 0 1 0 1",
               lat, rd, re, st, nreq, 2 + TIMEOUT_CYCLES);
    end
    model(1'b0, 1'b0, 32'h30, 2'b10, '0, '0, ed, ee);
    txn(1'b0, 32'h30, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (lat !== 3 || rd !== ed || re !== 1'b0) begin
      errs++;
      $display("FAIL after_timeout: lat=%0d data=%h err=%b, required 3 %h 0", lat, rd, re, ed);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nreq, seen; logic [31:0] rd; bit re, st, acc; logic [31:0] ed; bit ee;
    hang = 1'b1; acc = 1'b0;
    lq_req_valid = 1'b1; lq_addr = 32'h24; lq_size = 2'b10;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (lq_req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    lq_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (!acc || {lq_req_ready, sb_req_ready, lq_resp_valid, lq_resp_data, lq_resp_error,
                 sb_resp_valid, sb_resp_data, sb_resp_error, mem_req, mem_we, mem_atomic,
                 mem_addr, mem_wdata, mem_cmp_val, mem_size} !== '0) begin
      errs++;
      $display("FAIL reset_in_wait: accepted=%b mem_addr=%h, required accepted and all outputs 0",
               acc, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; hang = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (lq_resp_valid || sb_resp_valid) seen++;
    end
    @(posedge clk); #1;
    checks++;
    if (seen != 0) begin
      errs++;
      $display("FAIL reset_no_resp: pulses=%0d, required 0", seen);
    end
    model(1'b0, 1'b0, 32'h24, 2'b10, '0, '0, ed, ee);
    txn(1'b0, 32'h24, 2'b10, '0, '0, 1'b0, lat, rd, re, st, nreq);
    checks++;
    if (lat !== 3 || rd !== ed || re !== 1'b0 || st) begin
      errs++;
      $display("FAIL after_reset: lat=%0d data=%h err=%b, required 3 %h 0", lat, rd, re, ed);
    end
  endtask

  task automatic test_random();
    int lat, nreq; logic [31:0] rd; bit re, st; logic [31:0] ed; bit ee;
    bit is_sb, at; logic [31:0] a, wd, cv; logic [1:0] s;
    for (int k = 0; k < 40; k++) begin
      is_sb = ($urandom_range(0, 1) == 1);
      s = 2'($urandom_range(0, 2));
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        else if (s == 2'b10) a[1:0] = 2'b00;
      end
      at = is_sb && ($urandom_range(0, 2) == 0);
      wd = $urandom;
      cv = ($urandom_range(0, 1) == 1) ? ref_mem[a[7:2]] : $urandom;
      model(is_sb, at, a, s, wd, cv, ed, ee);
      txn(is_sb, a, s, wd, cv, at, lat, rd, re, st, nreq);
      checks++;
      if (lat !== (ee ? 2 : 3) || rd !== ed || re !== ee || st || nreq != 1) begin
        errs++;
        $display("FAIL random%0d sb=%b cas=%b a=%h s=%0d: lat=%0d data=%h err=%b stray=%b nreq=%0d, required %0d %h %b 0 1",
                 k, is_sb, at, a, s, lat, rd, re, st, nreq, ee ? 2 : 3, ed, ee);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    #1;
    test_reset();
    test_write_then_load();
    test_misaligned();
    test_cas();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
